wave_gen_core: RTL and testbench

//   Multi-waveform DDS core for the AWG DAC channel: sawtooth, square and sine (plus optional triangle).

---
 rtl/wave_pkg.sv | 36 +++
 rtl/sin_lut.sv | 39 +++
 rtl/wave_gen_core.sv | 111 +++++++++++
 tb/tb_wave_gen_core.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the AWG waveform core: bus widths, waveform select
// codes and the elaboration-time quarter-sine table generator.
package wave_pkg;

  localparam int unsigned DAC_W     = 14;
  localparam int unsigned PHASE_W   = 16;
  localparam int unsigned LUT_DEPTH = 257;

  localparam logic [1:0] SEL_SAW = 2'd0;
  localparam logic [1:0] SEL_SQR = 2'd1;
  localparam logic [1:0] SEL_SIN = 2'd2;
  localparam logic [1:0] SEL_TRI = 2'd3;

  // round(amp * sin(pi/2 * idx/256)) using Q30 fixed-point Taylor series,
  // so the table is built from integers only at elaboration time.
  function automatic logic [DAC_W-1:0] lut_val(input int idx, input int amp);
    logic [63:0] x;
    logic [63:0] term;
    logic [63:0] pos;
    logic [63:0] neg;
    logic [63:0] res;
    x    = (64'd3373259426 * 64'(idx)) >> 9;  // pi*2^30 * idx / 512
    term = x;
    pos  = x;
    neg  = 64'd0;
    for (int k = 1; k <= 12; k++) begin
      term = (((term * x) >> 30) * x) >> 30;
      term = term / 64'((2 * k) * (2 * k + 1));
      if (k % 2 == 1) neg = neg + term;
      else            pos = pos + term;
    end
    res = (64'(amp) * (pos - neg) + 64'd536870912) >> 30;
    return DAC_W'(res);
  endfunction

endpackage

// File: rtl/sin_lut.sv
// Quarter-wave sine ROM plus quadrant mirror/sign logic (combinational).
// Ports:
//   phase  in  16  phase accumulator value; [15:14] quadrant, [13:6] table index
//   sample out 14  offset-binary sine sample
module sin_lut
  import wave_pkg::*;
#(
  parameter logic [DAC_W-1:0] SIN_MID = 14'd8192,
  parameter int               SIN_AMP = 8191
) (
  input  logic [PHASE_W-1:0] phase,
  output logic [DAC_W-1:0]   sample
);

  localparam logic [8:0] LAST_IDX = 9'(LUT_DEPTH - 1);

  logic [DAC_W-1:0] lut [LUT_DEPTH];
  logic [1:0]       quad;
  logic [7:0]       idx;
  logic [8:0]       addr;
  logic [DAC_W-1:0] mag;
  logic             unused_phase_lsb;

  // Constant table, one entry per generate slot
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
    localparam logic [DAC_W-1:0] VAL = lut_val(g, SIN_AMP);
    assign lut[g] = VAL;
  end

  assign quad = phase[15:14];
  assign idx  = phase[13:6];
  assign unused_phase_lsb = ^phase[5:0];

  // Odd quadrants read the table backwards; 257 entries make i=0 hit the peak
  assign addr   = quad[0] ? (LAST_IDX - {1'b0, idx}) : {1'b0, idx};
  assign mag    = lut[addr];
  assign sample = quad[1] ? (SIN_MID - mag) : (SIN_MID + mag);

endmodule

// File: rtl/wave_gen_core.sv
// Multi-waveform DDS core: sawtooth, square, sine and (with TRI_WAVE_EN
// defined) triangle, two-stage registered path to a 14-bit offset-binary DAC.
// Optional feature macro: TRI_WAVE_EN (sel=3 selects triangle; otherwise 0).
// Ports:
//   clk       in   1   sample clock
//   rst_n     in   1   async active-low reset
//   en        in   1   advance counter / phase accumulator when 1
//   sel       in   2   0 saw, 1 square, 2 sine, 3 triangle/off
//   phase_inc in   16  sine phase increment per enabled clock
//   dac_data  out  14  registered DAC sample
//   dac_clk   out  1   clk pass-through
//   dac_wr    out  1   inverted clk write strobe
module wave_gen_core
  import wave_pkg::*;
#(
  parameter logic [DAC_W-1:0] CNT_STEP = 14'd1,
  parameter logic [DAC_W-1:0] SQR_HI   = 14'h3FFF,
  parameter logic [DAC_W-1:0] SIN_MID  = 14'd8192,
  parameter int               SIN_AMP  = 8191
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         sel,
  input  logic [PHASE_W-1:0] phase_inc,
  output logic [DAC_W-1:0]   dac_data,
  output logic               dac_clk,
  output logic               dac_wr
);

  logic [DAC_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  logic [DAC_W-1:0]   s_saw;
  logic [DAC_W-1:0]   s_sqr;
  logic [DAC_W-1:0]   s_sin;
  logic [DAC_W-1:0]   sin_c;
  logic [DAC_W-1:0]   mux_c;

  // Ramp counter and phase accumulator, both wrap silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= '0;
    end else if (en) begin
      cnt   <= cnt + CNT_STEP;
      phase <= phase + phase_inc;
    end
  end

  sin_lut #(
    .SIN_MID (SIN_MID),
    .SIN_AMP (SIN_AMP)
  ) u_sin_lut (
    .phase  (phase),
    .sample (sin_c)
  );

  // Stage 1: per-waveform sample registers, updated every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_saw <= '0;
      s_sqr <= '0;
      s_sin <= '0;
    end else begin
      s_saw <= cnt;
      s_sqr <= cnt[DAC_W-1] ? SQR_HI : '0;
      s_sin <= sin_c;
    end
  end

`ifdef TRI_WAVE_EN
  logic [DAC_W-1:0] s_tri;
  logic [DAC_W-1:0] tri_c;

  // Doubled ramp on the rising half, its complement on the falling half
  assign tri_c = cnt[DAC_W-1] ? ~{cnt[DAC_W-2:0], 1'b0} : {cnt[DAC_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_tri <= '0;
    else        s_tri <= tri_c;
  end
`endif

  // Output select
  always_comb begin
    mux_c = '0;
    case (sel)
      SEL_SAW: mux_c = s_saw;
      SEL_SQR: mux_c = s_sqr;
      SEL_SIN: mux_c = s_sin;
      SEL_TRI: begin
`ifdef TRI_WAVE_EN
        mux_c = s_tri;
`else
        mux_c = '0;
`endif
      end
      default: mux_c = '0;
    endcase
  end

  // Stage 2: DAC output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dac_data <= '0;
    else        dac_data <= mux_c;
  end

  assign dac_clk = clk;
  assign dac_wr  = ~clk;

endmodule

// File: tb/tb_wave_gen_core.sv
// Directed self-checking bench for wave_gen_core.
module tb_wave_gen_core;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [15:0] phase_inc;
  logic [13:0] dac_data;
  logic        dac_clk;
  logic        dac_wr;

  int checks = 0;
  int errors = 0;
  int k;
  int c;

`ifdef TRI_WAVE_EN
  localparam int TRI_LEN = 16386;
`else
  localparam int TRI_LEN = 64;
`endif

  wave_gen_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sel       (sel),
    .phase_inc (phase_inc),
    .dac_data  (dac_data),
    .dac_clk   (dac_clk),
    .dac_wr    (dac_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lut_ref(input int i);
    real v;
    v = 8191.0 * $sin(3.141592653589793 * i / 512.0);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int sin_ref(input int ph);
    int q;
    int i;
    q = (ph >> 14) & 3;
    i = (ph >> 6) & 255;
    case (q)
      0:       return 8192 + lut_ref(i);
      1:       return 8192 + lut_ref(256 - i);
      2:       return 8192 - lut_ref(i);
      default: return 8192 - lut_ref(256 - i);
    endcase
  endfunction

  function automatic int tri_ref(input int cv);
    if (cv < 8192) return 2 * cv;
    return 16383 - 2 * (cv - 8192);
  endfunction

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    sel       = 2'd0;
    phase_inc = 16'd0;

    // Reset held while clocking
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_dac", int'(dac_data), 0);
    end
    check("dac_clk_high", int'(dac_clk), 1);
    check("dac_wr_high", int'(dac_wr), 0);
    #5;
    check("dac_clk_low", int'(dac_clk), 0);
    check("dac_wr_low", int'(dac_wr), 1);
    step();
    rst_n = 1'b1;

    // Sawtooth from reset through the wrap; after edge k output is cnt value k-2
    for (k = 1; k <= 16386; k++) begin
      step();
      check("saw", int'(dac_data), (k >= 2) ? ((k - 2) % 16384) : 0);
    end

    // Square, continuing the same counter
    sel = 2'd1;
    for (int j = 0; j < 16384; j++) begin
      step();
      c = (k - 2) % 16384;
      check("square", int'(dac_data), (c >= 8192) ? 16383 : 0);
      k++;
    end

    // Sine, 16 samples per period from phase 0
    sel       = 2'd2;
    phase_inc = 16'h1000;
    step();
    check("sin_first", int'(dac_data), 8192);
    for (int j = 0; j < 32; j++) begin
      step();
      check("sin_model", int'(dac_data), sin_ref((j * 16'h1000) & 16'hFFFF));
      if (j == 0)  check("sin_s0", int'(dac_data), 8192);
      if (j == 2)  check("sin_s2", int'(dac_data), 13984);
      if (j == 4)  check("sin_s4", int'(dac_data), 16383);
      if (j == 8)  check("sin_s8", int'(dac_data), 8192);
      if (j == 12) check("sin_s12", int'(dac_data), 1);
    end

    // Mid-cycle asynchronous reset while running
    sel       = 2'd0;
    phase_inc = 16'd0;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", int'(dac_data), 0);
    step();
    check("async_reset_hold", int'(dac_data), 0);
    rst_n = 1'b1;

    // Restart, then pause with en=0 and resume
    for (k = 1; k <= 10; k++) begin
      step();
      check("restart", int'(dac_data), (k >= 2) ? (k - 2) : 0);
    end
    en = 1'b0;
    step(); check("hold_11", int'(dac_data), 9);
    step(); check("hold_12", int'(dac_data), 10);
    step(); check("hold_13", int'(dac_data), 10);
    step(); check("hold_14", int'(dac_data), 10);
    step(); check("hold_15", int'(dac_data), 10);
    en = 1'b1;
    step(); check("resume_16", int'(dac_data), 10);
    step(); check("resume_17", int'(dac_data), 10);
    step(); check("resume_18", int'(dac_data), 11);
    step(); check("resume_19", int'(dac_data), 12);
    step(); check("resume_20", int'(dac_data), 13);

    // sel=3: triangle when enabled, otherwise constant zero
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sel   = 2'd3;
    for (k = 1; k <= TRI_LEN; k++) begin
      step();
`ifdef TRI_WAVE_EN
      check("triangle", int'(dac_data), (k >= 2) ? tri_ref((k - 2) % 16384) : 0);
`else
      check("sel3_zero", int'(dac_data), 0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
